m_digit_scanner: RTL and testbench
==================================

// Module: m_digit_scanner
// PURPOSE
//  Time-multiplexed scan driver for a DIGITS-wide common-anode 7-segment display.
//  Sits directly upstream of m_seven_segment. It holds a DIGITS*4-bit value and
//  presents one nibble at a time on nib. It also drives the active-low digit
//  enables and the decimal point, and suppresses leading zeros.
//  Double-buffered: a new value takes effect only at a frame boundary, so a
//  frame never mixes two values.
// PARAMETERS
//  DIGITS  4      number of digits scanned; idx 0 = least significant nibble (rightmost digit)
//  DIV     50000  clocks per digit slot; must be >= 2
//  GUARD   16     dead clocks at the start of each slot with all digits off; 0 <= GUARD < DIV
// PORTS
//  clk      in   1         system clock, rising edge
//  rst      in   1         synchronous reset, active-high
//  load     in   1         1-cycle strobe: capture val/dp_in into the shadow register
//  val      in   4*DIGITS  hex value; nibble k goes to digit k
//  dp_in    in   DIGITS    decimal point request per digit, 1 = lit
//  blank_lz in   1         1 = enable leading-zero blanking (level, sampled every cycle)
//  nib      out  4         nibble for the current digit; drives m_seven_segment idat
//  blank    out  1         1 = current digit is suppressed (downstream forces segments off)
//  dp_n     out  1         active-low decimal point for the current digit
//  dig_n    out  DIGITS    active-low digit enables; at most one bit low at any time
//  frame    out  1         1-cycle pulse on the last clock of each full scan
// BEHAVIOUR
//  - State registers:
//      cnt   0..DIV-1 slot prescaler
//      idx   0..DIGITS-1 slot state
//      cur / cur_dp   displayed value and decimal points
//      shd / shd_dp   shadow value and decimal points
//      pend  1 = shadow holds an update not yet displayed
//  - Outputs are combinational from registered state only; no input-to-output path.
//  - Reset (sync, any cycle, including mid-scan): next cycle cnt=0, idx=0, cur=shd=0, dps=0, pend=0.
//    Resulting outputs: nib=0, blank=0, dp_n=1, frame=0, dig_n=all 1s (GUARD phase; idx 0 if GUARD=0).
//  - Slot FSM: states SLOT0..SLOT(DIGITS-1), each DIV clocks long.
//    tick = (cnt==DIV-1); on tick cnt<=0 and idx<=idx+1, wrapping DIGITS-1 -> 0; otherwise cnt<=cnt+1.
//    Frame period = DIGITS*DIV clocks.
//  - Phases within a slot:
//      GUARD phase (cnt < GUARD): dig_n = all 1s
//      ON phase (cnt >= GUARD):   dig_n bit idx = 0 unless blank=1, in which case all 1s
//  - nib = cur[4*idx+3 : 4*idx]; dp_n = ~cur_dp[idx].
//  - blank = blank_lz & (idx!=0) & ~cur_dp[idx] & (cur nibbles idx..DIGITS-1 all zero).
//    Digit 0 is never blanked, so value 0 shows a single "0".
//  - frame = tick & (idx==DIGITS-1).
//  - Load: on load, shd<=val, shd_dp<=dp_in, pend<=1. Repeated loads before a frame: last one wins.
//  - Frame commit: when frame=1 and pend=1, cur<=shd, cur_dp<=shd_dp, pend<=0.
//    If load=1 in the same cycle as frame, val/dp_in bypass into cur directly and pend<=0.
//  - New data is first visible in SLOT0 of the next frame; worst-case latency from load is DIGITS*DIV clocks.
//  - rst has priority over load and over the commit.
// TESTING (DIGITS=4, DIV=8, GUARD=2 unless stated)
//  1. rst, load val=16'h12AF, dp_in=0, blank_lz=0, run 2 frames ->
//     after 1st frame pulse nib = F,A,2,1 in slots 0..3;
//     dig_n = 4'b1111 for cnt 0..1 and 4'b1110 for cnt 2..7 in slot 0.
//  2. cur=16'h1111, load 16'h2222 in slot 1 ->
//     slots 1..3 of that frame still show 1; next frame shows 2 in all slots; frame pulses every 32 clocks.
//  3. blank_lz=1, val=16'h0005 -> slots 1..3: blank=1, dig_n=4'b1111; slot 0: nib=5, blank=0.
//     Then val=16'h0000 -> slot 0 shows nib=0, blank=0.
//  4. blank_lz=1, val=16'h0005, dp_in=4'b0100 -> slot 2: blank=0, nib=0, dp_n=0; slots 1 and 3 blanked.
//  5. rst asserted at idx=2, cnt=5 -> next cycle cnt=0, idx=0, dig_n=4'b1111, nib=0, dp_n=1, frame=0.
//  6. load val=16'hBEEF in the exact frame cycle -> next cycle slot 0 shows nib=F, pend=0.
//     GUARD=0 run: dig_n has exactly one low bit every cycle.

Source files
------------

// File: rtl/m_digit_scanner.sv
// Scan driver for a multiplexed common-anode 7-segment display: one nibble per slot,
// double-buffered value that only changes on frame boundaries, optional leading-zero blanking.
module m_digit_scanner #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   val,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [3:0]            nib,
  output logic                  blank,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [4*DIGITS-1:0]   cur, cur_nx, shd, shd_nx;
  logic [DIGITS-1:0]     cur_dp, cur_dp_nx, shd_dp, shd_dp_nx;
  logic                  pend, pend_nx;
  logic                  blz;
  logic                  tick;
  logic                  upper_zero;
  logic                  in_guard;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      cur    <= '0;
      cur_dp <= '0;
      shd    <= '0;
      shd_dp <= '0;
      pend   <= 1'b0;
      blz    <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      cur    <= cur_nx;
      cur_dp <= cur_dp_nx;
      shd    <= shd_nx;
      shd_dp <= shd_dp_nx;
      pend   <= pend_nx;
      blz    <= blank_lz;
    end
  end

  always_comb begin
    tick      = (cnt == CW'(DIV - 1));
    frame     = tick && (idx == IW'(DIGITS - 1));
    cnt_nx    = tick ? '0 : cnt + CW'(1);
    idx_nx    = idx;
    cur_nx    = cur;
    cur_dp_nx = cur_dp;
    shd_nx    = shd;
    shd_dp_nx = shd_dp;
    pend_nx   = pend;

    if (tick)
      idx_nx = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

    // A load landing on the frame cycle goes straight to the display so it is not delayed a full frame.
    if (frame && load) begin
      cur_nx    = val;
      cur_dp_nx = dp_in;
      shd_nx    = val;
      shd_dp_nx = dp_in;
      pend_nx   = 1'b0;
    end else if (frame && pend) begin
      cur_nx    = shd;
      cur_dp_nx = shd_dp;
      pend_nx   = 1'b0;
    end else if (load) begin
      shd_nx    = val;
      shd_dp_nx = dp_in;
      pend_nx   = 1'b1;
    end
  end

  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (int'(idx) <= k && cur[4*k +: 4] != 4'h0)
        upper_zero = 1'b0;
    end
    nib      = cur[{idx, 2'b00} +: 4];
    dp_n     = ~cur_dp[idx];
    blank    = blz && (idx != '0) && !cur_dp[idx] && upper_zero;
    in_guard = int'(cnt) < GUARD;
    dig_n    = '1;
    if (!in_guard && !blank)
      dig_n[idx] = 1'b0;
  end

endmodule

// File: tb/tb_m_digit_scanner.sv
// Randomized + directed bench for m_digit_scanner against a cycle-count based reference model.
module tb_m_digit_scanner;
  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;
  localparam int FR     = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst, load, blank_lz;
  logic [15:0] val;
  logic [3:0]  dp_in;
  logic [3:0]  nib, nib0;
  logic        blank, dp_n, frame, blank0, dp_n0, frame0;
  logic [3:0]  dig_n, dig_n0;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: position derived from cycles since reset
  int          t;
  logic [15:0] m_cur, m_shd;
  logic [3:0]  m_cdp, m_sdp;
  bit          m_pend, m_blz, m_valid;

  always #5 clk = ~clk;

  m_digit_scanner #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) u_dut (
    .clk(clk), .rst(rst), .load(load), .val(val), .dp_in(dp_in), .blank_lz(blank_lz),
    .nib(nib), .blank(blank), .dp_n(dp_n), .dig_n(dig_n), .frame(frame));

  m_digit_scanner #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(0)) u_g0 (
    .clk(clk), .rst(rst), .load(load), .val(val), .dp_in(dp_in), .blank_lz(blank_lz),
    .nib(nib0), .blank(blank0), .dp_n(dp_n0), .dig_n(dig_n0), .frame(frame0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  function automatic int slot();
    return (t / DIV) % DIGITS;
  endfunction

  function automatic bit exp_blank();
    int s = slot();
    return m_blz && s != 0 && !m_cdp[s] && ((m_cur >> (4 * s)) == 16'h0);
  endfunction

  task automatic check_outputs();
    int   s  = slot();
    int   c  = t % DIV;
    bit   eb = exp_blank();
    logic [3:0] edig;
    edig = 4'hF;
    if (c >= GUARD && !eb) edig[s] = 1'b0;
    chk("nib",   nib,   (m_cur >> (4 * s)) & 16'hF);
    chk("dp_n",  dp_n,  !m_cdp[s]);
    chk("blank", blank, eb);
    chk("dig_n", dig_n, edig);
    chk("frame", frame, (t % FR) == FR - 1);
    if (!blank0) chk("g0_one_low", $countones(~dig_n0), 1);
    else         chk("g0_blanked", dig_n0, 4'hF);
    chk("g0_blank", blank0, eb);
  endtask

  // drive one cycle of inputs, advance the model, then check the settled outputs
  task automatic cyc(input bit r, input bit ld, input logic [15:0] v, input logic [3:0] d, input bit b);
    bit fr;
    rst = r; load = ld; val = v; dp_in = d; blank_lz = b;
    if (r) begin
      t = 0; m_cur = 0; m_shd = 0; m_cdp = 0; m_sdp = 0; m_pend = 0; m_blz = 0; m_valid = 1;
    end else if (m_valid) begin
      fr = (t % FR) == FR - 1;
      if (fr && ld) begin
        m_cur = v; m_cdp = d; m_shd = v; m_sdp = d; m_pend = 0;
      end else if (fr && m_pend) begin
        m_cur = m_shd; m_cdp = m_sdp; m_pend = 0;
      end else if (ld) begin
        m_shd = v; m_sdp = d; m_pend = 1;
      end
      m_blz = b;
      t++;
    end
    @(negedge clk);
    if (m_valid) check_outputs();
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 4'h0, b);
  endtask

  task automatic run_to(input int s, input int c, input bit b);
    int guard_cnt = 0;
    while (!((t % DIV) == c && slot() == s) && guard_cnt < 2 * FR) begin
      cyc(0, 0, 16'h0, 4'h0, b);
      guard_cnt++;
    end
    if (guard_cnt >= 2 * FR) chk("run_to_timeout", guard_cnt, 0);
  endtask

  initial begin
    logic [15:0] rv;
    logic [3:0]  rd;
    bit          rb;
    m_valid = 0; t = 0;
    rst = 1; load = 0; val = 0; dp_in = 0; blank_lz = 0;
    @(negedge clk);

    // reset state
    cyc(1, 0, 16'h0, 4'h0, 0);
    chk("rst_dig_n", dig_n, 4'hF);
    chk("rst_nib", nib, 4'h0);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_frame", frame, 1'b0);
    chk("rst_blank", blank, 1'b0);

    // plain value, two frames
    cyc(0, 1, 16'h12AF, 4'h0, 0);
    idle(2 * FR, 0);

    // update mid-frame must wait for the next frame
    cyc(0, 1, 16'h1111, 4'h0, 0);
    run_to(1, 3, 0);
    cyc(0, 1, 16'h2222, 4'h0, 0);
    idle(2 * FR, 0);

    // leading-zero blanking, then zero value
    cyc(0, 1, 16'h0005, 4'h0, 1);
    idle(2 * FR, 1);
    run_to(1, 4, 1);
    chk("lz_dig_n_slot1", dig_n, 4'hF);
    cyc(0, 1, 16'h0000, 4'h0, 1);
    idle(2 * FR, 1);
    run_to(0, 4, 1);
    chk("zero_nib", nib, 4'h0);
    chk("zero_blank", blank, 1'b0);

    // decimal point stops blanking of its digit
    cyc(0, 1, 16'h0005, 4'b0100, 1);
    idle(2 * FR, 1);
    run_to(2, 4, 1);
    chk("dp_slot2_blank", blank, 1'b0);
    chk("dp_slot2_dp_n", dp_n, 1'b0);

    // reset mid-scan
    run_to(2, 5, 1);
    cyc(1, 0, 16'h0, 4'h0, 1);
    chk("mid_rst_dig_n", dig_n, 4'hF);
    chk("mid_rst_frame", frame, 1'b0);

    // load coinciding with the frame pulse bypasses the shadow
    run_to(3, 7, 0);
    chk("frame_pulse", frame, 1'b1);
    cyc(0, 1, 16'hBEEF, 4'h0, 0);
    chk("bypass_nib", nib, 4'hF);
    idle(FR, 0);

    // randomized traffic
    rb = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++)
        rv[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 49) == 0) rb = ~rb;
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0, rv, rd, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
